grey_frame_threshold: RTL and testbench

Streaming binarizer placed directly downstream of the RGB-to-grey converter. Accepts one 8-bit grey pixel per handshake and emits a black/white pixel (0x00/0xFF) by comparing against a threshold. The threshold is the integer mean of the previous full frame, so each frame adapts to the previous frame's brightness. Feeds the output-file writer and display stage with a registered valid/ready stream and per-frame markers.

---
 rtl/grey_frame_threshold.sv | 80 ++++++++
 tb/tb_grey_frame_threshold.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/grey_frame_threshold.sv
// Purpose: binarize a grey pixel stream against the previous frame's mean brightness.
// Latency: 1 cycle from input accept to registered output; threshold/frame_done commit with out_last.
// Backpressure: single output register; in_ready = !out_valid || out_ready, so a stall holds the output and blocks input.
module grey_frame_threshold #(
  parameter int          IMG_W       = 128,
  parameter int          IMG_H       = 128,
  parameter logic [7:0]  INIT_THRESH = 8'd128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_pix,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_pix,
  output logic       out_last,
  output logic [7:0] thresh,
  output logic       frame_done
);

  // Frame size must be a power of two so the mean is a plain shift.
  localparam int NPIX = IMG_W * IMG_H;
  localparam int LOG  = $clog2(NPIX);
  localparam int SW   = LOG + 8;

  logic [LOG-1:0] pix_cnt;
  logic [SW-1:0]  sum;
  logic [SW-1:0]  sum_next;
  logic           accept;
  logic           is_last;

  // Handshake and frame-position decode.
  always_comb begin
    in_ready = !out_valid || out_ready;
    accept   = in_valid && in_ready;
    is_last  = (pix_cnt == LOG'(NPIX - 1));
    sum_next = sum + SW'(in_pix);
  end

  // Output register: reload on accept, clear valid on a drain without refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pix   <= 8'h00;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_pix   <= (in_pix >= thresh) ? 8'hFF : 8'h00;
      out_last  <= is_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Frame statistics: running sum and pixel count; commit the mean on the last pixel.
  // The last pixel is compared against the old threshold above, since thresh updates here at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt    <= '0;
      sum        <= '0;
      thresh     <= INIT_THRESH;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        if (is_last) begin
          thresh     <= sum_next[SW-1:LOG];
          sum        <= '0;
          pix_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          sum     <= sum_next;
          pix_cnt <= pix_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_grey_frame_threshold.sv
// Purpose: scoreboard bench for grey_frame_threshold on a reduced 16x16 frame.
// Latency: expects each accepted pixel one cycle later, in order, with the new threshold on out_last.
// Backpressure: drives in_valid gaps and out_ready stalls, including a held 5-cycle stall.
module tb_grey_frame_threshold;

  localparam int IMG_W = 16;
  localparam int IMG_H = 16;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int LOG   = $clog2(NPIX);
  localparam logic [7:0] INIT = 8'd128;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_pix = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_pix;
  logic       out_last;
  logic [7:0] thresh;
  logic       frame_done;

  grey_frame_threshold #(.IMG_W(IMG_W), .IMG_H(IMG_H), .INIT_THRESH(INIT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
    .out_last(out_last), .thresh(thresh), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pix;
    logic       last;
    logic [7:0] thr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   fd_seen = 0;
  int   m_frames = 0;
  int   m_cnt = 0;
  int   m_sum = 0;
  logic [7:0] m_thr = INIT;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: called once per accepted pixel, in accept order.
  task automatic model_push(input logic [7:0] p);
    exp_t e;
    e.pix  = (p >= m_thr) ? 8'hFF : 8'h00;
    e.last = (m_cnt == NPIX - 1);
    m_sum  = m_sum + int'(p);
    if (e.last) begin
      m_thr = 8'(m_sum >> LOG);
      m_sum = 0;
      m_cnt = 0;
      m_frames++;
    end else begin
      m_cnt++;
    end
    e.thr = m_thr;
    sb_q.push_back(e);
  endtask

  // One cycle of stimulus; inputs change on the falling edge, accept decided before the rising edge.
  task automatic drive(input logic v, input logic [7:0] p, input logic ordy, output logic acc);
    @(negedge clk);
    in_valid  = v;
    in_pix    = p;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (acc) model_push(p);
  endtask

  task automatic send_pix(input logic [7:0] p, input int gap_pct, input int stall_pct);
    logic acc;
    logic v;
    logic o;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc) begin
      v = (int'($urandom_range(99)) >= gap_pct);
      o = (int'($urandom_range(99)) >= stall_pct);
      drive(v, v ? p : 8'($urandom), o, acc);
      n++;
      if (!acc && n > 1000) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) drive(1'b0, 8'($urandom), 1'b1, acc);
    drive(1'b0, 8'h00, 1'b1, acc);
    chk("drain_empty", sb_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_thr = INIT;
    m_sum = 0;
    m_cnt = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pix", out_pix, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_thresh", thresh, INIT);
    chk("rst_in_ready", in_ready, 1);
  endtask

  // Monitor: pop and compare every output the sink consumes.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (frame_done === 1'b1) begin
        fd_seen++;
        chk("frame_done_with_last", int'(out_last && out_valid), 1);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1 && rst === 1'b0) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("out_pix", out_pix, e.pix);
          chk("out_last", out_last, e.last);
          if (e.last) chk("thresh_at_last", thresh, e.thr);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic [7:0] bp_p;
    repeat (2) @(negedge clk);
    do_reset();

    // Flat 0x80 frame: equal to threshold gives white, threshold stays 0x80.
    for (int i = 0; i < NPIX; i++) send_pix(8'h80, 0, 0);
    drain();
    chk("flat80_thresh", thresh, 8'h80);

    // Two dark frames: first all black, threshold adapts to 0x40, second all white.
    for (int i = 0; i < 2 * NPIX; i++) send_pix(8'h40, 0, 0);
    drain();
    chk("dark_thresh", thresh, 8'h40);

    // Ramp frame: mean 127.5 floors to 0x7F.
    for (int i = 0; i < NPIX; i++) send_pix(8'(i), 0, 0);
    drain();
    chk("ramp_thresh", thresh, 8'h7F);

    // Next frame: straddle the new threshold, then a held stall mid-frame.
    send_pix(8'h7E, 0, 0);
    send_pix(8'h7F, 0, 0);
    for (int i = 0; i < 100; i++) send_pix(8'($urandom), 0, 0);
    bp_p = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, bp_p, 1'b0, acc);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      if (sb_q.size() != 0) chk("bp_hold_pix", out_pix, sb_q[0].pix);
      else chk("bp_queue", 0, 1);
    end
    send_pix(bp_p, 0, 0);
    for (int i = 0; i < NPIX - 103; i++) send_pix(8'($urandom), 0, 0);
    drain();

    // Reset mid-frame discards partial 0x10 data.
    for (int i = 0; i < 100; i++) send_pix(8'h10, 0, 0);
    drain();
    do_reset();
    for (int i = 0; i < NPIX; i++) send_pix(8'h90, 0, 0);
    drain();
    chk("after_rst_thresh", thresh, 8'h90);

    // Random pixels with random input gaps and output stalls.
    for (int i = 0; i < 3 * NPIX; i++) send_pix(8'($urandom), 30, 30);
    drain();

    chk("frame_done_count", fd_seen, m_frames);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
